// File: rtl/chargen_banked.sv
// chargen_banked: character generator with NUM_SETS downloadable 8-bit glyph banks
// behind a single dot-fetch port.
//
// Optional build macro: CHARGEN_INVERT_EN
//   defined   - dot_inv travels with each fetch; dotD is the inverted byte when set
//   undefined - dot_inv is ignored, dotD is the raw glyph byte
//
// Ports
//   clk_sys      system clock, all logic on rising edge
//   reset        asynchronous active-high reset (RAM contents are not touched)
//   profile      requested bank, adopted at the next frame_start
//   frame_start  one-cycle frame boundary pulse
//   dot_rd/dotA  fetch strobe and glyph byte address
//   dot_inv      reverse-video request for this fetch
//   dotD         glyph byte, holds its last value when dot_valid is low
//   dot_valid    one-cycle pulse, two cycles after dot_rd
//   active_bank  bank used for fetches in the current frame
//   rom_id/rom_addr/rom_wr/rom_data  download bus, one byte per rom_wr cycle
//   bank_loaded  per-bank "contents complete" flag
module chargen_banked #(
  parameter int NUM_SETS    = 2,
  parameter int ADDR_W      = 13,
  parameter int ROM_ID_BASE = 12,
  parameter int SEL_W       = 3
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [SEL_W-1:0]    profile,
  input  logic                frame_start,
  input  logic                dot_rd,
  input  logic [ADDR_W-1:0]   dotA,
  input  logic                dot_inv,
  output logic [7:0]          dotD,
  output logic                dot_valid,
  output logic [SEL_W-1:0]    active_bank,
  input  logic [5:0]          rom_id,
  input  logic [13:0]         rom_addr,
  input  logic                rom_wr,
  input  logic [7:0]          rom_data,
  output logic [NUM_SETS-1:0] bank_loaded
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [NUM_SETS*8-1:0] q_all;
  logic [SEL_W-1:0]      bank_c1;
  logic                  v_c1;
  logic [7:0]            rd_byte;
  logic [7:0]            out_byte;
  logic                  addr_zero;

  assign addr_zero = (rom_addr == 14'd0);

  for (genvar k = 0; k < NUM_SETS; k++) begin : g_bank
    logic [7:0]      mem [DEPTH];
    logic [7:0]      q_r;
    logic            we;
    logic            loaded_r;
    logic [ADDR_W:0] cnt_r;
    logic [ADDR_W:0] cnt_inc;

    // rom_addr[13] marks addresses outside the glyph space
    assign we      = rom_wr && !rom_addr[13] && (32'(rom_id) == ROM_ID_BASE + k);
    assign cnt_inc = cnt_r + CNT_ONE;

    // Read and write in one block with non-blocking updates: a same-cycle
    // collision returns the old byte.
    always_ff @(posedge clk_sys) begin
      if (we)
        mem[rom_addr[ADDR_W-1:0]] <= rom_data;
      if (dot_rd)
        q_r <= mem[dotA];
    end

    // Writing address 0 starts a fresh download; the bank is complete once
    // 2**ADDR_W strobes have landed. Writes to a complete bank are patches.
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        loaded_r <= 1'b1;
        cnt_r    <= '0;
      end else if (we) begin
        if (addr_zero) begin
          loaded_r <= 1'b0;
          cnt_r    <= CNT_ONE;
        end else if (!loaded_r) begin
          cnt_r <= cnt_inc;
          if (cnt_inc == CNT_FULL)
            loaded_r <= 1'b1;
        end
      end
    end

    assign q_all[k*8 +: 8] = q_r;
    assign bank_loaded[k]  = loaded_r;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      active_bank <= '0;
    else if (frame_start)
      active_bank <= (32'(profile) < NUM_SETS) ? profile : '0;
  end

  always_comb begin
    rd_byte = '0;
    for (int k = 0; k < NUM_SETS; k++)
      if (32'(bank_c1) == k)
        rd_byte = q_all[k*8 +: 8];
  end

`ifdef CHARGEN_INVERT_EN
  logic inv_c1;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      inv_c1 <= 1'b0;
    else if (dot_rd)
      inv_c1 <= dot_inv;
  end

  assign out_byte = inv_c1 ? ~rd_byte : rd_byte;
`else
  logic unused_dot_inv;

  assign unused_dot_inv = dot_inv;
  assign out_byte       = rd_byte;
`endif

  // bank_c1 samples active_bank before a coincident frame_start updates it,
  // so that fetch still comes from the old bank.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      v_c1      <= 1'b0;
      bank_c1   <= '0;
      dot_valid <= 1'b0;
      dotD      <= '0;
    end else begin
      v_c1      <= dot_rd;
      dot_valid <= v_c1;
      if (dot_rd)
        bank_c1 <= active_bank;
      if (v_c1)
        dotD <= out_byte;
    end
  end

endmodule
